// File: rtl/core_pkg.sv
// Shared widths and the write-request type used by the writeback path.
package core_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry FIFO of buffered producer-B writes; exposes per-entry rd/valid
// so the hazard query can see every buffered destination.
module wb_fifo
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        push_i,
    input  wb_req_t                     push_req_i,
    input  logic                        pop_i,
    output wb_req_t                     head_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [DEPTH-1:0]            entry_valid_o,
    output logic [DEPTH*REG_ADDR_W-1:0] entry_rd_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    wb_req_t          mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop_i ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + CntW'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CntW'(1);
        end
        // Push and pop never target the same slot: push is blocked when full.
        valid_d = valid_q;
        if (pop_i) begin
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (push_i) begin
            valid_d[wr_ptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_req_i;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry_rd
        assign entry_rd_o[i*REG_ADDR_W +: REG_ADDR_W] = mem_q[i].rd;
    end

    assign head_o        = mem_q[rd_ptr_q];
    assign full_o        = (count_q == CntW'(DEPTH));
    assign empty_o       = (count_q == '0);
    assign entry_valid_o = valid_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Arbitrates the register file write port between the in-order pipeline (A)
// and the buffered long-latency unit (B), with starvation-driven stall.
module writeback_arbiter
    import core_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  a_valid_i,
    input  logic [REG_ADDR_W-1:0] a_rd_i,
    input  logic [XLEN-1:0]       a_data_i,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    input  logic [REG_ADDR_W-1:0] b_rd_i,
    input  logic [XLEN-1:0]       b_data_i,
    output logic                  stall_o,
    input  logic [REG_ADDR_W-1:0] query_rd_i,
    output logic                  query_pending_o,
    output logic [REG_ADDR_W-1:0] write_register_o,
    output logic [XLEN-1:0]       write_back_data_o,
    output logic                  ctrl_write_back_o
);

    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

    logic                        fifo_full, fifo_empty;
    logic                        push, pop, sel_a, hit;
    wb_req_t                     head, b_req;
    logic [DEPTH-1:0]            entry_valid;
    logic [DEPTH*REG_ADDR_W-1:0] entry_rd;
    logic [StarveW-1:0]          starve_q, starve_d;
    logic                        stall_q, stall_d;
    logic                        wb_en_q, wb_en_d;
    logic [REG_ADDR_W-1:0]       wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]             wb_data_q, wb_data_d;

    assign b_req     = '{rd: b_rd_i, data: b_data_i};
    assign b_ready_o = !fifo_full;
    assign push      = b_valid_i && !fifo_full && (b_rd_i != '0);

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .push_i       (push),
        .push_req_i   (b_req),
        .pop_i        (pop),
        .head_o       (head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .entry_valid_o(entry_valid),
        .entry_rd_o   (entry_rd)
    );

    always_comb begin
        // A is masked while stalled, so a non-empty FIFO always wins then.
        sel_a     = !stall_q && a_valid_i && (a_rd_i != '0);
        pop       = !fifo_empty && !sel_a;
        wb_en_d   = sel_a || pop;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        if (pop) begin
            wb_rd_d   = head.rd;
            wb_data_d = head.data;
        end else if (sel_a) begin
            wb_rd_d   = a_rd_i;
            wb_data_d = a_data_i;
        end
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (starve_q == StarveW'(STARVE_LIMIT)) begin
            starve_d = starve_q;
        end else begin
            starve_d = starve_q + StarveW'(1);
        end
        stall_d = (starve_d == StarveW'(STARVE_LIMIT));
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            starve_q  <= '0;
            stall_q   <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            starve_q  <= starve_d;
            stall_q   <= stall_d;
            wb_en_q   <= wb_en_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    always_comb begin
        hit = wb_en_q && (wb_rd_q == query_rd_i);
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_rd[i*REG_ADDR_W +: REG_ADDR_W] == query_rd_i)) begin
                hit = 1'b1;
            end
        end
        query_pending_o = (query_rd_i != '0) && hit;
    end

    assign stall_o           = stall_q;
    assign write_register_o  = wb_rd_q;
    assign write_back_data_o = wb_data_q;
    assign ctrl_write_back_o = wb_en_q;

`ifndef SYNTHESIS
    a_during_stall: assert property (@(posedge clk_i) disable iff (reset_i)
        !(a_valid_i && stall_q))
        else $error("a_valid_i asserted while stall_o is high; A write dropped");
`endif

endmodule
